// File: rtl/delay_line_ram.sv
// Circular FIR sample store: tap-relative reads, 1-cycle latency (2 with DELAY_LINE_OUT_REG_EN), zero-fill sweep.
// Backpressure: ready=0 while sweeping; push and rd_en are dropped then, and clear wins over both in the same cycle.
module delay_line_ram #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] tap,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  ready,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full
);

  localparam int                  DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   ONE_CNT   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE_ADDR  = ADDR_WIDTH'(1);

  typedef enum logic {
    S_CLEAR,
    S_IDLE
  } state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   wr_ptr, wr_ptr_nxt;
  logic [ADDR_WIDTH-1:0]   clr_ptr, clr_ptr_nxt;
  logic [ADDR_WIDTH:0]     count_nxt;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdat;
  logic                    rd_acc;
  logic [ADDR_WIDTH-1:0]   raddr;
  logic [DATA_WIDTH-1:0]   rd_dat;
  logic                    rd_vld;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // Tap 0 is the slot just behind the write pointer, taken before any same-cycle push.
  assign raddr = wr_ptr - ONE_ADDR - tap;
  assign ready = (state == S_IDLE);
  assign full  = (count == DEPTH_CNT);

  always_comb begin
    state_nxt   = state;
    wr_ptr_nxt  = wr_ptr;
    clr_ptr_nxt = clr_ptr;
    count_nxt   = count;
    mem_we      = 1'b0;
    mem_waddr   = wr_ptr;
    mem_wdat    = din;
    rd_acc      = 1'b0;
    case (state)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr;
        mem_wdat  = '0;
        if (clear) begin
          clr_ptr_nxt = '0;
        end else begin
          clr_ptr_nxt = clr_ptr + ONE_ADDR;
          if (clr_ptr == LAST_ADDR) begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_IDLE: begin
        if (clear) begin
          state_nxt   = S_CLEAR;
          wr_ptr_nxt  = '0;
          clr_ptr_nxt = '0;
          count_nxt   = '0;
        end else begin
          rd_acc = rd_en;
          if (push) begin
            mem_we     = 1'b1;
            mem_waddr  = wr_ptr;
            mem_wdat   = din;
            wr_ptr_nxt = wr_ptr + ONE_ADDR;
            if (count != DEPTH_CNT) begin
              count_nxt = count + ONE_CNT;
            end
          end
        end
      end
      default: begin
        state_nxt   = S_CLEAR;
        clr_ptr_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_CLEAR;
      wr_ptr  <= '0;
      clr_ptr <= '0;
      count   <= '0;
    end else begin
      state   <= state_nxt;
      wr_ptr  <= wr_ptr_nxt;
      clr_ptr <= clr_ptr_nxt;
      count   <= count_nxt;
    end
  end

  // Storage carries no reset; the sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdat;
    end
  end

  // Read-before-write: a collision with the push slot returns the old contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_dat <= '0;
      rd_vld <= 1'b0;
    end else begin
      rd_vld <= rd_acc;
      if (rd_acc) begin
        rd_dat <= mem[raddr];
      end
    end
  end

`ifdef DELAY_LINE_OUT_REG_EN
  logic [DATA_WIDTH-1:0] out_dat;
  logic                  out_vld;

  // Second stage keeps draining regardless of clear so in-flight reads complete.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_dat <= '0;
      out_vld <= 1'b0;
    end else begin
      out_vld <= rd_vld;
      if (rd_vld) begin
        out_dat <= rd_dat;
      end
    end
  end

  assign dout       = out_dat;
  assign dout_valid = out_vld;
`else
  assign dout       = rd_dat;
  assign dout_valid = rd_vld;
`endif

endmodule

// File: tb/tb_delay_line_ram.sv
// Scoreboard bench for delay_line_ram: reads queue expected data and arrival cycle, a monitor pops and compares.
module tb_delay_line_ram;

  localparam int AW    = 5;
  localparam int DW    = 16;
  localparam int DEPTH = 32;
`ifdef DELAY_LINE_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk;
  logic          rst;
  logic          clear;
  logic          push;
  logic [DW-1:0] din;
  logic          rd_en;
  logic [AW-1:0] tap;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          ready;
  logic [AW:0]   count;
  logic          full;

  delay_line_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .push       (push),
    .din        (din),
    .rd_en      (rd_en),
    .tap        (tap),
    .dout       (dout),
    .dout_valid (dout_valid),
    .ready      (ready),
    .count      (count),
    .full       (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [DW-1:0] dat;
    int            due;
    int            tap;
  } exp_t;

  exp_t          sb[$];
  int            n_vec = 0;
  int            n_bad = 0;
  logic [DW-1:0] m_mem [DEPTH];
  int            m_wp;
  int            m_cnt;
  bit            m_idle;

  // Monitor: every dout_valid must match the head of the scoreboard, on its due cycle.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (!rst) begin
        if (dout_valid === 1'b1) begin
          n_vec++;
          if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_valid cyc=%0d dout=%h, required no dout_valid", cyc, dout);
          end else begin
            exp_t e;
            e = sb.pop_front();
            if (dout !== e.dat || cyc !== e.due) begin
              n_bad++;
              $display("FAIL read_data tap=%0d got %h at cyc %0d, required %h at cyc %0d",
                       e.tap, dout, cyc, e.dat, e.due);
            end
          end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
          exp_t e;
          n_vec++;
          n_bad++;
          e = sb.pop_front();
          $display("FAIL missing_valid tap=%0d at cyc %0d, required dout=%h with dout_valid at cyc %0d",
                   e.tap, cyc, e.dat, e.due);
        end
      end
    end
  end

  // One clock of stimulus; the model decides what the DUT must return.
  task automatic step(input logic p, input logic [DW-1:0] d, input logic r,
                      input logic [AW-1:0] t, input logic c);
    exp_t e;
    int   idx;
    push  = p;
    din   = d;
    rd_en = r;
    tap   = t;
    clear = c;
    if (m_idle) begin
      if (c) begin
        m_idle = 1'b0;
        m_wp   = 0;
        m_cnt  = 0;
      end else begin
        if (r) begin
          idx   = (m_wp - 1 - int'(t)) & (DEPTH - 1);
          e.dat = m_mem[idx];
          e.due = cyc + LAT;
          e.tap = int'(t);
          sb.push_back(e);
        end
        if (p) begin
          m_mem[m_wp] = d;
          m_wp = (m_wp + 1) % DEPTH;
          if (m_cnt < DEPTH) m_cnt++;
        end
      end
    end
    @(posedge clk);
    #1;
    push  = 1'b0;
    rd_en = 1'b0;
    clear = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (ready !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    rd_en = 1'b0;
    if (ready !== 1'b1) begin
      n_vec++;
      n_bad++;
      $display("FAIL ready_timeout ready=%b after %0d cycles, required 1", ready, n);
    end
    foreach (m_mem[i]) m_mem[i] = '0;
    m_wp   = 0;
    m_cnt  = 0;
    m_idle = 1'b1;
  endtask

  task automatic drain();
    repeat (LAT + 2) step(1'b0, '0, 1'b0, '0, 1'b0);
    n_vec++;
    if (sb.size() !== 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_count(input string nm, input int exp_cnt, input logic exp_full);
    n_vec++;
    if (count !== (AW+1)'(exp_cnt) || full !== exp_full) begin
      n_bad++;
      $display("FAIL %s count=%0d full=%b, required count=%0d full=%b", nm, count, full, exp_cnt, exp_full);
    end
  endtask

  task automatic read_all_taps();
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, AW'(i), 1'b0);
    drain();
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    m_idle = 1'b0;
    sb.delete();
    #2;
    n_vec++;
    if (dout !== '0 || dout_valid !== 1'b0 || ready !== 1'b0 || count !== '0 || full !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state dout=%h vld=%b ready=%b count=%0d full=%b, required all 0",
               dout, dout_valid, ready, count, full);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    wait_ready(n);
    n_vec++;
    if (n !== DEPTH) begin
      n_bad++;
      $display("FAIL sweep_len ready after %0d cycles, required %0d", n, DEPTH);
    end
    check_count("reset_count", 0, 1'b0);
    read_all_taps();
  endtask

  task automatic test_push3();
    step(1'b1, 16'h0011, 1'b0, '0, 1'b0);
    step(1'b1, 16'h0022, 1'b0, '0, 1'b0);
    step(1'b1, 16'h0033, 1'b0, '0, 1'b0);
    check_count("push3_count", 3, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, AW'(i), 1'b0);
    drain();
    n_vec++;
    if (dout !== 16'h0011) begin
      n_bad++;
      $display("FAIL push3_last dout=%h, required 0011", dout);
    end
  endtask

  task automatic test_wrap();
    for (int v = 1; v <= 40; v++) step(1'b1, DW'(v), 1'b0, '0, 1'b0);
    check_count("wrap_count", DEPTH, 1'b1);
    step(1'b0, '0, 1'b1, AW'(0), 1'b0);
    step(1'b0, '0, 1'b1, AW'(31), 1'b0);
    drain();
    n_vec++;
    if (dout !== 16'd9) begin
      n_bad++;
      $display("FAIL wrap_tap31 dout=%0d, required 9", dout);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 16'h0100, 1'b0, '0, 1'b0);
    step(1'b1, 16'h0200, 1'b1, AW'(0), 1'b0);
    step(1'b0, '0, 1'b1, AW'(0), 1'b0);
    // Collision: oldest slot is both read (tap 31) and overwritten.
    step(1'b1, 16'hABCD, 1'b1, AW'(31), 1'b0);
    step(1'b0, '0, 1'b1, AW'(0), 1'b0);
    drain();
    n_vec++;
    if (dout !== 16'hABCD) begin
      n_bad++;
      $display("FAIL b2b_newest dout=%h, required abcd", dout);
    end
    check_count("b2b_count", DEPTH, 1'b1);
  endtask

  task automatic test_clear();
    int n;
    for (int v = 0; v < 10; v++) step(1'b1, DW'(16'h1000 + v), 1'b0, '0, 1'b0);
    step(1'b1, 16'h5555, 1'b1, AW'(0), 1'b1);
    n_vec++;
    if (ready !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_ready ready=%b, required 0", ready);
    end
    check_count("clear_count", 0, 1'b0);
    wait_ready(n);
    n_vec++;
    if (n !== DEPTH) begin
      n_bad++;
      $display("FAIL clear_sweep_len ready after %0d cycles, required %0d", n, DEPTH);
    end
    check_count("clear_after", 0, 1'b0);
    read_all_taps();
  endtask

  task automatic test_reset_sweep();
    int n;
    rst   = 1'b1;
    m_idle = 1'b0;
    sb.delete();
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      n_vec++;
      if (ready !== 1'b0) begin
        n_bad++;
        $display("FAIL sweep_ready cycle %0d ready=%b, required 0", i, ready);
      end
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (dout_valid !== 1'b0 || count !== '0) begin
      n_bad++;
      $display("FAIL rst_mid_sweep vld=%b count=%0d, required 0 0", dout_valid, count);
    end
    @(posedge clk);
    #1;
    rst   = 1'b0;
    rd_en = 1'b1;
    wait_ready(n);
    n_vec++;
    if (n !== DEPTH) begin
      n_bad++;
      $display("FAIL resweep_len ready after %0d cycles, required %0d", n, DEPTH);
    end
    drain();
    test_push3();
  endtask

  initial begin
    rst   = 1'b1;
    clear = 1'b0;
    push  = 1'b0;
    din   = '0;
    rd_en = 1'b0;
    tap   = '0;
    m_idle = 1'b0;
    m_wp  = 0;
    m_cnt = 0;
    foreach (m_mem[i]) m_mem[i] = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_push3();
    test_wrap();
    test_back_to_back();
    test_clear();
    test_reset_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
